// File: rtl/neuron_relu_output_stage_pkg.sv
// Shared types and constants for the ReLU/requantize output stage.
package neuron_relu_output_stage_pkg;

   localparam int unsigned IN_W_DEF  = 18;
   localparam int unsigned OUT_W_DEF = 8;
   localparam int unsigned SHIFT_W   = 5;
   localparam int unsigned SHIFT_MAX = 17;

   typedef struct packed {
      logic [OUT_W_DEF-1:0] act;
      logic                 sat;
   } act_entry_t;

   localparam int unsigned ENTRY_W = $bits(act_entry_t);

endpackage

// File: rtl/neuron_relu_output_stage_sync_fifo.sv
// Synchronous FIFO with occupancy count; head is read straight from storage (no fall-through).
module neuron_relu_output_stage_sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW    = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Pop only when non-empty; push only when there is room after any pop.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((32'(count_q) < DEPTH) || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/neuron_relu_output_stage.sv
// ReLU, rounded right-shift requantization and unsigned saturation of the MAC sum,
// buffered in a small FIFO toward the next layer, with a saturation event counter.
module neuron_relu_output_stage
   import neuron_relu_output_stage_pkg::*;
#(
   parameter int unsigned IN_W       = IN_W_DEF,
   parameter int unsigned OUT_W      = OUT_W_DEF,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    sum_in,
   input  logic [4:0]         shift_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   act_out,
   output logic               sat_out,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   sat_count
);

   localparam int unsigned   EXT_W   = IN_W + 1;
   localparam int unsigned   FCNT_W  = $clog2(FIFO_DEPTH+1);
   localparam logic [EXT_W-1:0] ACT_MAX = EXT_W'((1 << OUT_W) - 1);

   logic [4:0]        shift_clamp;
   logic [EXT_W-1:0]  relu;
   logic [EXT_W-1:0]  q;
   act_entry_t        entry;

   logic              s1_valid_q, s1_valid_d;
   act_entry_t        s1_entry_q, s1_entry_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  sat_count_q, sat_count_d;
   act_entry_t        hold_q, hold_d;
   act_entry_t        head;
   logic [FCNT_W-1:0] fifo_count;
   logic [FCNT_W-1:0] count_next;
   logic              accept, pop;

   // Datapath: extra top bit keeps the rounding add from overflowing.
   always_comb begin
      shift_clamp = (shift_in > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : shift_in;
      relu        = sum_in[IN_W-1] ? '0 : {1'b0, sum_in};
      if (shift_clamp == '0) q = relu;
      else q = (relu + (EXT_W'(1) << (shift_clamp - 5'd1))) >> shift_clamp;
      entry.sat = (q > ACT_MAX);
      entry.act = entry.sat ? '1 : q[OUT_W-1:0];
   end

   // in_ready looks at next-cycle occupancy so S1 always has a free FIFO slot.
   always_comb begin
      accept      = in_valid && in_ready_q;
      pop         = out_ready && out_valid;
      s1_valid_d  = accept;
      s1_entry_d  = accept ? entry : s1_entry_q;
      count_next  = fifo_count + FCNT_W'(s1_valid_q) - FCNT_W'(pop);
      in_ready_d  = (32'(count_next) + 32'(s1_valid_d)) < FIFO_DEPTH;
      hold_d      = pop ? head : hold_q;
      sat_count_d = sat_count_q;
      if (cnt_clr) sat_count_d = '0;
      else if (s1_valid_q && s1_entry_q.sat && (sat_count_q != '1))
         sat_count_d = sat_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_entry_q  <= '0;
         in_ready_q  <= 1'b0;
         sat_count_q <= '0;
         hold_q      <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_entry_q  <= s1_entry_d;
         in_ready_q  <= in_ready_d;
         sat_count_q <= sat_count_d;
         hold_q      <= hold_d;
      end
   end

   neuron_relu_output_stage_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s1_valid_q),
      .wdata (s1_entry_q),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count)
   );

   // When empty, present the last popped entry instead of stale storage.
   assign out_valid = (fifo_count != '0);
   assign act_out   = out_valid ? head.act : hold_q.act;
   assign sat_out   = out_valid ? head.sat : hold_q.sat;
   assign in_ready  = in_ready_q;
   assign sat_count = sat_count_q;

endmodule

// File: tb/tb_neuron_relu_output_stage.sv
// Self-checking bench: directed cases plus randomized stream against an arithmetic model.
module tb_neuron_relu_output_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] sum_in;
   logic [4:0]  shift_in;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  act_out;
   logic        sat_out;
   logic        cnt_clr;
   logic [15:0] sat_count;

   int tests = 0;
   int fails = 0;
   int model_sat = 0;
   logic [8:0] exp_q[$];   // {sat, act}

   always #5 clk = ~clk;

   neuron_relu_output_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_in    (sum_in),
      .shift_in  (shift_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .act_out   (act_out),
      .sat_out   (sat_out),
      .cnt_clr   (cnt_clr),
      .sat_count (sat_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [8:0] model(input logic [17:0] s, input logic [4:0] sh);
      int v, r, q, n;
      v = $signed(s);
      n = (sh > 5'd17) ? 17 : int'(sh);
      r = (v < 0) ? 0 : v;
      q = (n == 0) ? r : (r + (1 << (n - 1))) / (1 << n);
      if (q > 255) return {1'b1, 8'd255};
      return {1'b0, 8'(q)};
   endfunction

   // One clock: record transfers seen at this edge, check pops against the model.
   task automatic tick();
      logic [8:0] e;
      if (in_valid && in_ready) begin
         e = model(sum_in, shift_in);
         exp_q.push_back(e);
         if (e[8]) model_sat++;
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            chk("pop_act", 32'(act_out), 32'(e[7:0]));
            chk("pop_sat", 32'(sat_out), 32'(e[8]));
         end
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [17:0] s, input logic [4:0] sh);
      in_valid = 1'b1; sum_in = s; shift_in = sh;
      for (int i = 0; i < 50 && !in_ready; i++) tick();
      if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic head(input string tag, input logic [7:0] a, input logic s);
      for (int i = 0; i < 50 && !out_valid; i++) tick();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_act"}, 32'(act_out), 32'(a));
      chk({tag, "_sat"}, 32'(sat_out), 32'(s));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      bit acc;
      int sent;
      int acc_cnt;
      rst = 1'b1; in_valid = 1'b1; sum_in = '0; shift_in = '0;
      out_ready = 1'b0; cnt_clr = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sat_count", 32'(sat_count), 32'd0);
      chk("rst_act", 32'(act_out), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Negative input and latency
      in_valid = 1'b1; sum_in = 18'h3FFF0; shift_in = 5'd0;
      tick();
      in_valid = 1'b0;
      chk("lat_edge1_valid", 32'(out_valid), 32'd0);
      tick();
      chk("lat_edge2_valid", 32'(out_valid), 32'd1);
      head("neg", 8'd0, 1'b0);

      send(18'd1000, 5'd2); head("q1000", 8'd250, 1'b0);
      chk("empty_hold_act", 32'(act_out), 32'd250);
      chk("empty_valid", 32'(out_valid), 32'd0);
      send(18'd6, 5'd2);    head("round_up", 8'd2, 1'b0);
      send(18'd5, 5'd2);    head("round_dn", 8'd1, 1'b0);

      send(18'd1022, 5'd2); head("sat256", 8'd255, 1'b1);
      chk("sat_count1", 32'(sat_count), 32'd1);
      send(18'd131071, 5'd0); head("satmax", 8'd255, 1'b1);
      chk("sat_count2", 32'(sat_count), 32'd2);
      send(18'd40000, 5'd25); head("shift_clamp", 8'd0, 1'b0);

      // Backpressure: only FIFO_DEPTH accepted
      acc_cnt = 0;
      in_valid = 1'b1; sum_in = 18'd10; shift_in = 5'd0;
      for (int i = 0; i < 6; i++) begin
         acc = in_valid && in_ready;
         tick();
         if (acc) begin acc_cnt++; sum_in = sum_in + 18'd7; end
      end
      in_valid = 1'b0;
      chk("bp_accepted", 32'(acc_cnt), 32'd4);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      out_ready = 1'b0;
      chk("bp_drained", 32'(exp_q.size()), 32'd0);
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Clear wins over a saturated write in the same cycle
      in_valid = 1'b1; sum_in = 18'd131071; shift_in = 5'd0;
      tick();
      in_valid = 1'b0; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0; model_sat = 0;
      chk("clr_priority", 32'(sat_count), 32'd0);
      head("clr_entry", 8'd255, 1'b1);

      // Random stream with toggling out_ready
      sent = 0;
      in_valid = 1'b1; sum_in = 18'($urandom); shift_in = 5'($urandom_range(0, 20));
      for (int c = 0; c < 2000 && sent < 100; c++) begin
         acc = in_valid && in_ready;
         tick();
         out_ready = ~out_ready;
         if (acc) begin
            sent++;
            sum_in = 18'($urandom); shift_in = 5'($urandom_range(0, 20));
            if (sent >= 100) in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("rand_sent", 32'(sent), 32'd100);
      out_ready = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      out_ready = 1'b0;
      tick();
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      chk("rand_sat_count", 32'(sat_count), 32'(model_sat));

      // Reset mid-stream discards in-flight data
      in_valid = 1'b1; sum_in = 18'd300; shift_in = 5'd1;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_count", 32'(sat_count), 32'd0);
      @(negedge clk);
      exp_q.delete(); model_sat = 0;
      rst = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_valid", 32'(out_valid), 32'd0);
      end
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      send(18'd77, 5'd0); head("post_rst_data", 8'd77, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
